// File: rtl/joy_serial_pkg.sv
// Shared types and width helpers for the UserIO serial joystick scanner.
package joy_serial_pkg;

  typedef enum logic [2:0] {
    ST_GAP    = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LOW    = 3'd2,
    ST_HIGH   = 3'd3,
    ST_COMMIT = 3'd4
  } joy_state_e;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    if (max_val < 32'd2) begin
      w = 32'd1;
    end else begin
      w = $clog2(max_val + 32'd1);
    end
    return w;
  endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// Free-running prescaler: one registered tick every CLK_DIV cycles, restartable by clear.
module joy_tick_gen
  import joy_serial_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = cnt_width(CLK_DIV - 32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 32'd1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count; the tick flag is registered alongside so it is high exactly while count is last.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    tick_d = (cnt_d == CNT_LAST);
  end

  // Prescaler state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/joy_serial_scan.sv
// UserIO serial joystick scanner: drives load/clock for chained PISO adapters,
// deserialises the button stream and debounces whole frames before publishing.
module joy_serial_scan
  import joy_serial_pkg::*;
#(
  parameter int unsigned PLAYERS   = 2,
  parameter int unsigned BITS      = 12,
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned GAP_TICKS = 8,
  parameter int unsigned DEBOUNCE  = 2
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      joy_data,
  output logic                      joy_clk,
  output logic                      joy_load,
  output logic [PLAYERS*BITS-1:0]   joy_out,
  output logic                      frame_valid,
  output logic                      changed
);

  localparam int unsigned N     = PLAYERS * BITS;
  localparam int unsigned IDX_W = cnt_width(N - 32'd1);
  localparam int unsigned GAP_W = cnt_width(GAP_TICKS - 32'd1);
  localparam int unsigned STB_W = cnt_width(DEBOUNCE);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 32'd1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 32'd1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE);
  localparam logic [STB_W-1:0] STB_ONE  = STB_W'(32'd1);

  joy_state_e       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     cap_q, cap_d;
  logic [N-1:0]     cand_q, cand_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [N-1:0]     out_q, out_d;
  logic             fv_q, fv_d;
  logic             chg_q, chg_d;
  logic             joy_clk_q, joy_load_q;
  logic             tick_s;
  logic             clear_s;

  assign clear_s = ~enable;

  joy_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clear   (clear_s),
    .tick    (tick_s)
  );

  // Scan sequencer and frame debounce; a low enable overrides everything, including COMMIT.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    cap_d    = cap_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    out_d    = out_q;
    fv_d     = 1'b0;
    chg_d    = 1'b0;
    if (!enable) begin
      state_d  = ST_GAP;
      gap_d    = '0;
      idx_d    = '0;
      cap_d    = '0;
      cand_d   = '0;
      stable_d = '0;
      out_d    = '0;
    end else begin
      case (state_q)
        ST_GAP: begin
          if (tick_s) begin
            if (gap_q == GAP_LAST) begin
              gap_d   = '0;
              state_d = ST_LOAD;
            end else begin
              gap_d = gap_q + 1'b1;
            end
          end else begin
            gap_d = gap_q;
          end
        end
        ST_LOAD: begin
          if (tick_s) begin
            idx_d   = '0;
            state_d = ST_LOW;
          end else begin
            idx_d = idx_q;
          end
        end
        ST_LOW: begin
          // Wire level is active low; capture holds pressed = 1.
          if (tick_s) begin
            cap_d[idx_q] = ~joy_data;
            state_d      = ST_HIGH;
          end else begin
            state_d = ST_LOW;
          end
        end
        ST_HIGH: begin
          if (tick_s) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_COMMIT;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_LOW;
            end
          end else begin
            state_d = ST_HIGH;
          end
        end
        ST_COMMIT: begin
          if (cap_q == cand_q) begin
            if (stable_q == STB_MAX) begin
              stable_d = stable_q;
            end else begin
              stable_d = stable_q + 1'b1;
            end
          end else begin
            cand_d   = cap_q;
            stable_d = STB_ONE;
          end
          if (stable_d == STB_MAX) begin
            out_d = cand_d;
          end else begin
            out_d = out_q;
          end
          fv_d    = 1'b1;
          chg_d   = (out_d != out_q);
          state_d = ST_GAP;
        end
        default: begin
          state_d = ST_GAP;
        end
      endcase
    end
  end

  // State, datapath and registered pin/strobe outputs decoded from the next state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_GAP;
      gap_q      <= '0;
      idx_q      <= '0;
      cap_q      <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      out_q      <= '0;
      fv_q       <= 1'b0;
      chg_q      <= 1'b0;
      joy_clk_q  <= 1'b1;
      joy_load_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      cap_q      <= cap_d;
      cand_q     <= cand_d;
      stable_q   <= stable_d;
      out_q      <= out_d;
      fv_q       <= fv_d;
      chg_q      <= chg_d;
      joy_clk_q  <= (state_d != ST_LOW);
      joy_load_q <= (state_d != ST_LOAD);
    end
  end

  assign joy_clk     = joy_clk_q;
  assign joy_load    = joy_load_q;
  assign joy_out     = out_q;
  assign frame_valid = fv_q;
  assign changed     = chg_q;

endmodule

// File: tb/tb_joy_serial_scan.sv
// Directed bench for joy_serial_scan: default build plus a 1x16 / CLK_DIV=2 / DEBOUNCE=1 build.
module tb_joy_serial_scan;

  localparam int N  = 24;
  localparam int NS = 16;

  logic          clk_sys = 1'b0;
  logic          reset_n, enable, joy_data, joy_clk, joy_load, frame_valid, changed;
  logic [N-1:0]  joy_out, pat, sr;
  logic          rst_sw_n, en_sw, data_sw, clk_sw, load_sw, fv_sw, chg_sw;
  logic [NS-1:0] out_sw, pat_sw, sr_sw;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int at, base;
  logic strobe_seen;

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  joy_serial_scan #(
    .PLAYERS(2), .BITS(12), .CLK_DIV(16), .GAP_TICKS(8), .DEBOUNCE(2)
  ) u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .joy_data(joy_data),
    .joy_clk(joy_clk), .joy_load(joy_load), .joy_out(joy_out),
    .frame_valid(frame_valid), .changed(changed)
  );

  joy_serial_scan #(
    .PLAYERS(1), .BITS(16), .CLK_DIV(2), .GAP_TICKS(8), .DEBOUNCE(1)
  ) u_sw (
    .clk_sys(clk_sys), .reset_n(rst_sw_n), .enable(en_sw), .joy_data(data_sw),
    .joy_clk(clk_sw), .joy_load(load_sw), .joy_out(out_sw),
    .frame_valid(fv_sw), .changed(chg_sw)
  );

  // Daisy-chained PISO adapters: parallel load while load is low, shift on rising clock.
  always @(posedge joy_clk or negedge joy_load) begin
    if (!joy_load) sr <= ~pat;
    else           sr <= {1'b1, sr[N-1:1]};
  end
  assign joy_data = sr[0];

  always @(posedge clk_sw or negedge load_sw) begin
    if (!load_sw) sr_sw <= ~pat_sw;
    else          sr_sw <= {1'b1, sr_sw[NS-1:1]};
  end
  assign data_sw = sr_sw[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_load_low(input int sel, output int when);
    when = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_sys);
      if (((sel == 0) ? joy_load : load_sw) === 1'b0) begin
        when = cyc;
        break;
      end
    end
  endtask

  task automatic wait_fv(input int sel, output int when);
    when = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_sys);
      if (((sel == 0) ? frame_valid : fv_sw) === 1'b1) begin
        when = cyc;
        break;
      end
    end
  endtask

  initial begin
    reset_n  = 1'b1;
    enable   = 1'b1;
    rst_sw_n = 1'b1;
    en_sw    = 1'b1;
    pat      = 24'h800005;
    pat_sw   = 16'hA5C3;
    #3;
    reset_n  = 1'b0;
    rst_sw_n = 1'b0;
    #1;
    check("rst_joy_clk",  32'(joy_clk), 32'd1);
    check("rst_joy_load", 32'(joy_load), 32'd1);
    check("rst_joy_out",  32'(joy_out), 32'd0);
    check("rst_fv",       32'(frame_valid), 32'd0);
    check("rst_changed",  32'(changed), 32'd0);
    check("rst_sw_out",   32'(out_sw), 32'd0);

    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    base = cyc;
    repeat (127) @(negedge clk_sys);
    check("gap_load_high_127", 32'(joy_load), 32'd1);
    @(negedge clk_sys);
    check("load_low_128", 32'(joy_load), 32'd0);
    repeat (15) @(negedge clk_sys);
    check("load_low_143", 32'(joy_load), 32'd0);
    @(negedge clk_sys);
    check("load_end_144", 32'(joy_load), 32'd1);
    check("clk_low_144", 32'(joy_clk), 32'd0);
    repeat (16) @(negedge clk_sys);
    check("clk_high_160", 32'(joy_clk), 32'd1);

    wait_fv(0, at);
    check("commit1_time", at - base, 32'd913);
    check("commit1_out", 32'(joy_out), 32'd0);
    check("commit1_changed", 32'(changed), 32'd0);
    wait_load_low(0, at);
    check("frame_period", at - base, 32'd1040);
    wait_fv(0, at);
    check("commit2_time", at - base, 32'd1825);
    check("commit2_out", 32'(joy_out), 32'h800005);
    check("commit2_changed", 32'(changed), 32'd1);
    @(negedge clk_sys);
    check("fv_one_cycle", 32'(frame_valid), 32'd0);
    check("changed_one_cycle", 32'(changed), 32'd0);

    // Single-frame glitch on player 0 bit 3 must be rejected.
    pat = 24'h80000D;
    wait_fv(0, at);
    check("glitch_out", 32'(joy_out), 32'h800005);
    check("glitch_changed", 32'(changed), 32'd0);
    pat = 24'h800005;
    wait_fv(0, at);
    check("recover1_out", 32'(joy_out), 32'h800005);
    wait_fv(0, at);
    check("recover2_out", 32'(joy_out), 32'h800005);
    check("recover2_changed", 32'(changed), 32'd0);
    pat = 24'h80000D;
    wait_fv(0, at);
    check("hold1_out", 32'(joy_out), 32'h800005);
    check("hold1_changed", 32'(changed), 32'd0);
    wait_fv(0, at);
    check("hold2_out", 32'(joy_out), 32'h80000D);
    check("hold2_changed", 32'(changed), 32'd1);

    // Asynchronous reset while shifting bit 0.
    wait_load_low(0, at);
    repeat (20) @(negedge clk_sys);
    check("pre_rst_in_low", 32'(joy_clk), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_joy_clk", 32'(joy_clk), 32'd1);
    check("arst_joy_load", 32'(joy_load), 32'd1);
    check("arst_joy_out", 32'(joy_out), 32'd0);
    check("arst_fv", 32'(frame_valid), 32'd0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    base = cyc;
    wait_load_low(0, at);
    check("restart_load_128", at - base, 32'd128);
    wait_fv(0, at);
    check("restart_c1_time", at - base, 32'd913);
    check("restart_c1_out", 32'(joy_out), 32'd0);
    wait_fv(0, at);
    check("restart_c2_time", at - base, 32'd1825);
    check("restart_c2_out", 32'(joy_out), 32'h80000D);
    check("restart_c2_changed", 32'(changed), 32'd1);

    // Abort in HIGH of bit 10.
    wait_load_low(0, at);
    check("abort_frame_load", at - base, 32'd1952);
    repeat (355) @(negedge clk_sys);
    check("abort_in_high", 32'(joy_clk), 32'd1);
    enable = 1'b0;
    @(negedge clk_sys);
    check("abort_out", 32'(joy_out), 32'd0);
    check("abort_joy_clk", 32'(joy_clk), 32'd1);
    check("abort_joy_load", 32'(joy_load), 32'd1);
    check("abort_fv", 32'(frame_valid), 32'd0);
    check("abort_changed", 32'(changed), 32'd0);
    strobe_seen = 1'b0;
    repeat (500) begin
      @(negedge clk_sys);
      if (frame_valid !== 1'b0 || changed !== 1'b0 || joy_load !== 1'b1) strobe_seen = 1'b1;
    end
    check("abort_quiet", 32'(strobe_seen), 32'd0);
    enable = 1'b1;
    base = cyc;
    wait_load_low(0, at);
    check("reenable_load_128", at - base, 32'd128);

    // Parameter sweep instance.
    @(negedge clk_sys);
    rst_sw_n = 1'b1;
    base = cyc;
    wait_load_low(1, at);
    check("sw_load_16", at - base, 32'd16);
    wait_fv(1, at);
    check("sw_c1_time", at - base, 32'd83);
    check("sw_c1_out", 32'(out_sw), 32'h0000A5C3);
    check("sw_c1_changed", 32'(chg_sw), 32'd1);
    wait_fv(1, at);
    check("sw_period", at - base, 32'd165);
    check("sw_c2_changed", 32'(chg_sw), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
